// File: rtl/pong_pkg.sv
// Shared encodings for the Pong game-flow controller: state codes, menu item
// indices and the decoded button-event bundle.
package pong_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned MENU_CONTINUE = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_START = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Rising-edge events of the debounced buttons, one bit per button
    typedef struct packed {
        logic enter;
        logic up;
        logic down;
    } btn_ev_t;

    // Restart is always the last pause-menu entry
    function automatic int unsigned menu_restart(input int unsigned items);
        return items - 1;
    endfunction

endpackage

// File: rtl/pong_fsm_if.sv
// Front-end / game-core side bundle of the Pong game-flow controller.
// slave = the controller, master = whatever drives buttons and reads screens.
interface pong_fsm_if
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned MENU_ITEMS = 2
);
    localparam int unsigned MSEL_W = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1;

    logic               frame_tick;
    logic               enter;
    logic               up;
    logic               down;
    logic               point_p1;
    logic               point_p2;

    logic [STATE_W-1:0] state;
    logic               game_en;
    logic               menu_en;
    logic               show_start;
    logic               show_pause;
    logic               show_over;
    logic               game_reset;
    logic               serve;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               winner;
    logic [MSEL_W-1:0]  menu_sel;

    modport slave (
        input  frame_tick, enter, up, down, point_p1, point_p2,
        output state, game_en, menu_en, show_start, show_pause, show_over,
               game_reset, serve, score_p1, score_p2, winner, menu_sel
    );

    modport master (
        output frame_tick, enter, up, down, point_p1, point_p2,
        input  state, game_en, menu_en, show_start, show_pause, show_over,
               game_reset, serve, score_p1, score_p2, winner, menu_sel
    );

endinterface

// File: rtl/rise_edge.sv
// Rising-edge detector for a debounced level; the event is combinational
// (current & ~previous) and is suppressed in the first cycle after reset.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise_c
);
    logic r_prev;
    logic r_armed;

    // r_armed keeps a level held through reset from looking like a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_armed <= 1'b1;
        end
    end

    assign o_rise_c = i_sig & ~r_prev & r_armed;

endmodule

// File: rtl/pong_fsm.sv
// Pong game-flow controller: start menu, serve countdown, play, pause, game over.
// Optional feature macro: PONG_FSM_WIN_BY_TWO_EN (win needs a two-point lead, with deuce).
module pong_fsm
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_LIMIT  = 7,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MENU_ITEMS   = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    pong_fsm_if.slave bus
);
    localparam int unsigned MSEL_W = $clog2(MENU_ITEMS);
    localparam int unsigned CNT_W  = $clog2(SERVE_FRAMES + 1);

    localparam logic [SCORE_W-1:0] LIMIT     = SCORE_W'(SCORE_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [MSEL_W-1:0]  SEL_CONT  = MSEL_W'(MENU_CONTINUE);
    localparam logic [MSEL_W-1:0]  SEL_LAST  = MSEL_W'(menu_restart(MENU_ITEMS));

    btn_ev_t w_ev;

    state_e             r_state,      w_state;
    state_e             r_ret_state,  w_ret_state;
    logic [CNT_W-1:0]   r_cnt,        w_cnt;
    logic [SCORE_W-1:0] r_score_p1,   w_score_p1;
    logic [SCORE_W-1:0] r_score_p2,   w_score_p2;
    logic               r_winner,     w_winner;
    logic [MSEL_W-1:0]  r_menu_sel,   w_menu_sel;
    logic               r_serve,      w_serve;
    logic               r_game_reset, w_game_reset;
    logic               r_game_en;
    logic               r_menu_en;
    logic               r_show_start;
    logic               r_show_pause;
    logic               r_show_over;

    logic [SCORE_W-1:0] w_p1_inc;
    logic [SCORE_W-1:0] w_p2_inc;
    logic [SCORE_W-1:0] w_lead;
    logic [SCORE_W-1:0] w_trail;
    logic [SCORE_W-1:0] w_new_p1;
    logic [SCORE_W-1:0] w_new_p2;
    logic               w_win;

    rise_edge u_edge_enter (.clk(clk), .rst_n(rst_n), .i_sig(bus.enter), .o_rise_c(w_ev.enter));
    rise_edge u_edge_up    (.clk(clk), .rst_n(rst_n), .i_sig(bus.up),    .o_rise_c(w_ev.up));
    rise_edge u_edge_down  (.clk(clk), .rst_n(rst_n), .i_sig(bus.down),  .o_rise_c(w_ev.down));

    // Scores after a single-player point and the resulting win decision
    always_comb begin : p_score
        w_p1_inc = r_score_p1 + SCORE_W'(1);
        w_p2_inc = r_score_p2 + SCORE_W'(1);
        w_lead   = bus.point_p1 ? w_p1_inc : w_p2_inc;
        w_trail  = bus.point_p1 ? r_score_p2 : r_score_p1;
        w_new_p1 = bus.point_p1 ? w_p1_inc : r_score_p1;
        w_new_p2 = bus.point_p2 ? w_p2_inc : r_score_p2;
`ifdef PONG_FSM_WIN_BY_TWO_EN
        w_win = (w_lead >= LIMIT) && (w_lead > w_trail) &&
                ((w_lead - w_trail) >= SCORE_W'(2));
        // Deuce folds a tied late game back to LIMIT-1 so scores stay bounded
        if ((w_lead == w_trail) && (w_lead >= (LIMIT - SCORE_W'(1)))) begin
            w_new_p1 = LIMIT - SCORE_W'(1);
            w_new_p2 = LIMIT - SCORE_W'(1);
        end
`else
        w_win = (w_lead == LIMIT);
`endif
    end

    // Next-state and next-output decode
    always_comb begin : p_next
        w_state      = r_state;
        w_ret_state  = r_ret_state;
        w_cnt        = '0;
        w_score_p1   = r_score_p1;
        w_score_p2   = r_score_p2;
        w_winner     = r_winner;
        w_menu_sel   = '0;
        w_serve      = 1'b0;
        w_game_reset = 1'b1;

        case (r_state)
            ST_START: begin
                if (w_ev.enter) begin
                    w_state      = ST_SERVE;
                    w_score_p1   = '0;
                    w_score_p2   = '0;
                    w_winner     = 1'b0;
                    w_game_reset = 1'b0;
                end
            end

            ST_SERVE: begin
                w_cnt = r_cnt;
                if (w_ev.enter) begin
                    w_state     = ST_PAUSE;
                    w_ret_state = ST_SERVE;
                    w_cnt       = '0;
                end else if (bus.frame_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state = ST_PLAY;
                        w_serve = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                // A point always beats a same-cycle enter
                if (bus.point_p1 ^ bus.point_p2) begin
                    w_score_p1 = w_new_p1;
                    w_score_p2 = w_new_p2;
                    if (w_win) begin
                        w_state  = ST_OVER;
                        w_winner = bus.point_p2;
                    end else begin
                        w_state = ST_SERVE;
                    end
                end else if (bus.point_p1 && bus.point_p2) begin
                    w_state = ST_SERVE;
                end else if (w_ev.enter) begin
                    w_state     = ST_PAUSE;
                    w_ret_state = ST_PLAY;
                end
            end

            ST_PAUSE: begin
                w_menu_sel = r_menu_sel;
                if (w_ev.enter) begin
                    if (r_menu_sel == SEL_CONT) begin
                        w_state    = r_ret_state;
                        w_menu_sel = '0;
                    end else if (r_menu_sel == SEL_LAST) begin
                        w_state      = ST_START;
                        w_score_p1   = '0;
                        w_score_p2   = '0;
                        w_winner     = 1'b0;
                        w_menu_sel   = '0;
                        w_game_reset = 1'b0;
                    end
                end else if (w_ev.up && !w_ev.down) begin
                    w_menu_sel = (r_menu_sel == '0) ? SEL_LAST : r_menu_sel - MSEL_W'(1);
                end else if (w_ev.down && !w_ev.up) begin
                    w_menu_sel = (r_menu_sel == SEL_LAST) ? '0 : r_menu_sel + MSEL_W'(1);
                end
            end

            ST_OVER: begin
                if (w_ev.enter) begin
                    w_state      = ST_START;
                    w_score_p1   = '0;
                    w_score_p2   = '0;
                    w_winner     = 1'b0;
                    w_game_reset = 1'b0;
                end
            end

            default: begin
                w_state     = ST_START;
                w_ret_state = ST_SERVE;
                w_score_p1  = '0;
                w_score_p2  = '0;
                w_winner    = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_START;
            r_ret_state  <= ST_SERVE;
            r_cnt        <= '0;
            r_score_p1   <= '0;
            r_score_p2   <= '0;
            r_winner     <= 1'b0;
            r_menu_sel   <= '0;
            r_serve      <= 1'b0;
            r_game_reset <= 1'b0;
            r_game_en    <= 1'b0;
            r_menu_en    <= 1'b1;
            r_show_start <= 1'b1;
            r_show_pause <= 1'b0;
            r_show_over  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_ret_state  <= w_ret_state;
            r_cnt        <= w_cnt;
            r_score_p1   <= w_score_p1;
            r_score_p2   <= w_score_p2;
            r_winner     <= w_winner;
            r_menu_sel   <= w_menu_sel;
            r_serve      <= w_serve;
            r_game_reset <= w_game_reset;
            r_game_en    <= (w_state == ST_PLAY);
            r_menu_en    <= (w_state == ST_START) || (w_state == ST_PAUSE) ||
                            (w_state == ST_OVER);
            r_show_start <= (w_state == ST_START);
            r_show_pause <= (w_state == ST_PAUSE);
            r_show_over  <= (w_state == ST_OVER);
        end
    end

    assign bus.state      = r_state;
    assign bus.game_en    = r_game_en;
    assign bus.menu_en    = r_menu_en;
    assign bus.show_start = r_show_start;
    assign bus.show_pause = r_show_pause;
    assign bus.show_over  = r_show_over;
    assign bus.game_reset = r_game_reset;
    assign bus.serve      = r_serve;
    assign bus.score_p1   = r_score_p1;
    assign bus.score_p2   = r_score_p2;
    assign bus.winner     = r_winner;
    assign bus.menu_sel   = r_menu_sel;

endmodule

// File: tb/tb_pong_fsm.sv
// Directed bench for pong_fsm: reset, full games, a vector table for pause and
// corner cases, and a late-game sequence (win-by-two variant under PONG_FSM_WIN_BY_TWO_EN).
module tb_pong_fsm;

    localparam int unsigned SERVE_FRAMES = 60;
    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    typedef struct {
        int         n;
        logic       en, up, dn, tk, p1, p2;
        logic [2:0] st;
        int         s1, s2;
        logic       sel, srv, gr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t tbl[$];

    pong_fsm_if #(.SCORE_W(4), .MENU_ITEMS(2)) bus ();

    pong_fsm #(
        .SCORE_LIMIT (7),
        .SCORE_W     (4),
        .SERVE_FRAMES(SERVE_FRAMES),
        .MENU_ITEMS  (2)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic up, input logic dn, input logic tk,
                        input logic p1, input logic p2, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.enter      = en;
            bus.up         = up;
            bus.down       = dn;
            bus.frame_tick = tk;
            bus.point_p1   = p1;
            bus.point_p2   = p2;
            @(posedge clk);
            #1;
        end
    endtask

    // Full serve countdown from a fresh SERVE entry
    task automatic countdown(input string nm);
        step(0, 0, 0, 1, 0, 0, SERVE_FRAMES);
        chk({nm, " play"}, 32'(bus.state), 32'(S_PLAY));
        chk({nm, " serve"}, 32'(bus.serve), 32'd1);
    endtask

    // One point in PLAY; run the next countdown when the game continues
    task automatic point(input logic a1, input logic a2, input logic [2:0] est,
                         input int e1, input int e2, input string nm);
        step(0, 0, 0, 0, a1, a2, 1);
        chk({nm, " state"}, 32'(bus.state), 32'(est));
        chk({nm, " p1"}, 32'(bus.score_p1), 32'(e1));
        chk({nm, " p2"}, 32'(bus.score_p2), 32'(e2));
        if (est == S_SERVE) countdown(nm);
    endtask

    function automatic vec_t mk(input int n, input logic en, input logic up, input logic dn,
                                input logic tk, input logic p1, input logic p2,
                                input logic [2:0] st, input int s1, input int s2,
                                input logic sel, input logic srv, input logic gr);
        vec_t v;
        v.n = n; v.en = en; v.up = up; v.dn = dn; v.tk = tk; v.p1 = p1; v.p2 = p2;
        v.st = st; v.s1 = s1; v.s2 = s2; v.sel = sel; v.srv = srv; v.gr = gr;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //        n  en up dn tk p1 p2  state    s1 s2 sel srv gr
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk(59, 0, 0, 0, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 1, 0, 0, S_PLAY,  0, 0, 0, 1, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 1, 1, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk(60, 0, 0, 0, 1, 0, 0, S_PLAY,  0, 0, 0, 1, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, S_SERVE, 0, 1, 0, 0, 1));
        tbl.push_back(mk(60, 0, 0, 0, 1, 0, 0, S_PLAY,  0, 1, 0, 1, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 1, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 1, 1, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_PLAY,  0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PLAY,  0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, S_PAUSE, 0, 1, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PAUSE, 0, 1, 1, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_START, 0, 0, 0, 0, 0));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_START, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk(30, 0, 0, 0, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 5, 0, 0, 0, 1, 0, 0, S_PAUSE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk(59, 0, 0, 0, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 1, 0, 0, S_PLAY,  0, 0, 0, 1, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_PLAY,  0, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 1, 0, S_SERVE, 1, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, S_SERVE, 1, 0, 0, 0, 1));

        // Reset with enter held high throughout
        rst_n          = 1'b0;
        bus.enter      = 1'b1;
        bus.up         = 1'b0;
        bus.down       = 1'b0;
        bus.frame_tick = 1'b0;
        bus.point_p1   = 1'b0;
        bus.point_p2   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst state", 32'(bus.state), 32'(S_START));
        chk("rst show_start", 32'(bus.show_start), 32'd1);
        chk("rst menu_en", 32'(bus.menu_en), 32'd1);
        chk("rst game_en", 32'(bus.game_en), 32'd0);
        chk("rst show_pause", 32'(bus.show_pause), 32'd0);
        chk("rst show_over", 32'(bus.show_over), 32'd0);
        chk("rst serve", 32'(bus.serve), 32'd0);
        chk("rst winner", 32'(bus.winner), 32'd0);
        chk("rst game_reset", 32'(bus.game_reset), 32'd0);
        chk("rst scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);
        chk("rst menu_sel", 32'(bus.menu_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 3);
        chk("held enter state", 32'(bus.state), 32'(S_START));
        chk("post-rst game_reset", 32'(bus.game_reset), 32'd1);

        // First game: player 1 wins 7-0
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("g1 start state", 32'(bus.state), 32'(S_SERVE));
        chk("g1 game_reset low", 32'(bus.game_reset), 32'd0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("g1 game_reset high", 32'(bus.game_reset), 32'd1);
        chk("g1 point in serve", 32'(bus.score_p2), 32'd0);
        step(0, 0, 0, 1, 0, 0, SERVE_FRAMES - 1);
        chk("g1 tick59 state", 32'(bus.state), 32'(S_SERVE));
        chk("g1 tick59 serve", 32'(bus.serve), 32'd0);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("g1 tick60 state", 32'(bus.state), 32'(S_PLAY));
        chk("g1 tick60 serve", 32'(bus.serve), 32'd1);
        chk("g1 game_en", 32'(bus.game_en), 32'd1);
        chk("g1 menu_en", 32'(bus.menu_en), 32'd0);
        for (int i = 0; i < 7; i++)
            point(1, 0, (i == 6) ? S_OVER : S_SERVE, i + 1, 0, $sformatf("g1 pt%0d", i));
        chk("g1 winner", 32'(bus.winner), 32'd0);
        chk("g1 show_over", 32'(bus.show_over), 32'd1);
        chk("g1 over menu_en", 32'(bus.menu_en), 32'd1);
        chk("g1 over game_en", 32'(bus.game_en), 32'd0);
        step(0, 0, 0, 0, 1, 0, 1);
        chk("g1 point in over", 32'(bus.score_p1), 32'd7);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("g1 over->start", 32'(bus.state), 32'(S_START));
        chk("g1 over clear", 32'(bus.score_p1), 32'd0);
        chk("g1 over game_reset", 32'(bus.game_reset), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Vector table: simultaneous points, pause menu, pause from serve
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].up, tbl[i].dn, tbl[i].tk, tbl[i].p1, tbl[i].p2, tbl[i].n);
            chk($sformatf("row%0d state", i), 32'(bus.state), 32'(tbl[i].st));
            chk($sformatf("row%0d score_p1", i), 32'(bus.score_p1), 32'(tbl[i].s1));
            chk($sformatf("row%0d score_p2", i), 32'(bus.score_p2), 32'(tbl[i].s2));
            chk($sformatf("row%0d menu_sel", i), 32'(bus.menu_sel), 32'(tbl[i].sel));
            chk($sformatf("row%0d serve", i), 32'(bus.serve), 32'(tbl[i].srv));
            chk($sformatf("row%0d game_reset", i), 32'(bus.game_reset), 32'(tbl[i].gr));
        end

        // Reset in the middle of a game
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst state", 32'(bus.state), 32'(S_START));
        chk("mid rst score", 32'(bus.score_p1), 32'd0);
        chk("mid rst game_reset", 32'(bus.game_reset), 32'd0);
        chk("mid rst show_start", 32'(bus.show_start), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 2);
        chk("mid rst release", 32'(bus.game_reset), 32'd1);

        // Second game: alternate points to 6-6, then decide the late game
        step(1, 0, 0, 0, 0, 0, 1);
        chk("g2 start", 32'(bus.state), 32'(S_SERVE));
        countdown("g2 first");
        for (int i = 0; i < 6; i++) begin
            point(1, 0, S_SERVE, i + 1, i, $sformatf("g2 a%0d", i));
            point(0, 1, S_SERVE, i + 1, i + 1, $sformatf("g2 b%0d", i));
        end
`ifdef PONG_FSM_WIN_BY_TWO_EN
        point(0, 1, S_SERVE, 6, 7, "g2 adv p2");
        point(1, 0, S_SERVE, 6, 6, "g2 deuce");
        point(1, 0, S_SERVE, 7, 6, "g2 adv p1");
        point(1, 0, S_OVER, 8, 6, "g2 win");
        chk("g2 winner", 32'(bus.winner), 32'd0);
`else
        point(0, 1, S_OVER, 6, 7, "g2 win");
        chk("g2 winner", 32'(bus.winner), 32'd1);
`endif
        chk("g2 show_over", 32'(bus.show_over), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
